// File: rtl/pit_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pit_mem_arbiter
//
// Shares the single PIT packet-memory port between two burst requesters:
//   requester 0 : FIB-side ingress, writes packets into memory
//   requester 1 : PIT-side egress, reads packets out of memory
// Each grant covers one burst of BURST_LEN consecutive byte addresses starting
// at the owner's base address. Ties are broken round-robin.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   req[1:0]    level burst requests (bit 0 = write/ingress, bit 1 = read/egress)
//   base_addr0  burst start address of requester 0, sampled at grant
//   base_addr1  burst start address of requester 1, sampled at grant
//   wdata0      write byte from requester 0, consumed whenever wr_pop0 is high
//   mem_rdata   memory read data, valid in the cycle after the access is issued
//   gnt[1:0]    registered one-hot grant, held for the whole burst
//   wr_pop0     requester 0 must present the next byte on wdata0 this cycle
//   mem_addr    registered memory byte address
//   mem_wdata   registered memory write data
//   mem_we      registered memory write enable
//   rdata1      read byte returned to requester 1
//   rvalid1     rdata1 valid strobe
//   done[1:0]   one-cycle burst-complete pulse per requester
//   busy        registered, high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module pit_mem_arbiter #(
   parameter int ADDR_W    = 62,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] base_addr0,
   input  logic [ADDR_W-1:0] base_addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        gnt,
   output logic              wr_pop0,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   output logic [1:0]        done,
   output logic              busy
);

   localparam int              CNT_W    = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   // One-hot encoding so that a corrupted state register is detectable and
   // steered back to IDLE by the default branches below.
   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_GRANT = 4'b0010,
      S_BURST = 4'b0100,
      S_DONE  = 4'b1000
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              owner;
   logic              owner_nxt;
   logic              last;
   logic              last_nxt;
   logic              pick;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;

   logic [1:0]        gnt_nxt;
   logic [1:0]        done_nxt;
   logic              busy_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;
   logic              mem_we_nxt;
   logic              rd_vld_nxt;
   logic              rd_vld_p1;

   // Round-robin choice: a lone request wins outright; on a tie the requester
   // that was not served last wins.
   always_comb begin
      pick = req[1];
      if (req == 2'b11) begin
         pick = ~last;
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req != 2'b00) begin
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            state_nxt = S_BURST;
         end
         S_BURST: begin
            if (cnt == CNT_LAST) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output / datapath next-value logic
   // ---------------------------------------------------------------------------
   always_comb begin
      owner_nxt     = owner;
      last_nxt      = last;
      ptr_nxt       = ptr;
      cnt_nxt       = cnt;
      gnt_nxt       = gnt;
      done_nxt      = 2'b00;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_we_nxt    = 1'b0;
      rd_vld_nxt    = 1'b0;
      wr_pop0       = 1'b0;

      case (state)
         S_IDLE: begin
            if (req != 2'b00) begin
               owner_nxt = pick;
               ptr_nxt   = pick ? base_addr1 : base_addr0;
               cnt_nxt   = '0;
               gnt_nxt   = pick ? 2'b10 : 2'b01;
            end
         end
         S_GRANT: begin
            // setup cycle, no memory access
         end
         S_BURST: begin
            mem_addr_nxt = ptr;
            ptr_nxt      = ptr + ADDR_W'(1);
            cnt_nxt      = cnt + CNT_W'(1);
            if (!owner) begin
               // Requester 0 cannot stall: its byte is taken on this edge.
               wr_pop0       = 1'b1;
               mem_wdata_nxt = wdata0;
               mem_we_nxt    = 1'b1;
            end else begin
               rd_vld_nxt = 1'b1;
            end
         end
         S_DONE: begin
            gnt_nxt         = 2'b00;
            done_nxt[owner] = 1'b1;
            last_nxt        = owner;
         end
         default: begin
            // Corrupted state: return every register to its reset value.
            owner_nxt     = 1'b0;
            last_nxt      = 1'b1;
            ptr_nxt       = '0;
            cnt_nxt       = '0;
            gnt_nxt       = 2'b00;
            mem_addr_nxt  = '0;
            mem_wdata_nxt = '0;
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // Stage p0 -> p1: memory access issue and control registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= 1'b0;
         last      <= 1'b1;
         ptr       <= '0;
         cnt       <= '0;
         gnt       <= 2'b00;
         done      <= 2'b00;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         rd_vld_p1 <= 1'b0;
      end else begin
         owner     <= owner_nxt;
         last      <= last_nxt;
         ptr       <= ptr_nxt;
         cnt       <= cnt_nxt;
         gnt       <= gnt_nxt;
         done      <= done_nxt;
         busy      <= busy_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         mem_we    <= mem_we_nxt;
         rd_vld_p1 <= rd_vld_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p1: read return, one cycle behind the issuing BURST cycle
   // ---------------------------------------------------------------------------
   // The memory answers the registered address within the following cycle, so
   // the return is forwarded directly and gated to zero when not valid.
   assign rvalid1 = rd_vld_p1;
   assign rdata1  = rd_vld_p1 ? mem_rdata : '0;

endmodule

// File: tb/tb_pit_mem_arbiter.sv
module tb_pit_mem_arbiter;

   localparam int AW = 62;
   localparam int DW = 8;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req;
   logic [AW-1:0] base_addr0;
   logic [AW-1:0] base_addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] mem_rdata;
   logic [1:0]    gnt;
   logic          wr_pop0;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] rdata1;
   logic          rvalid1;
   logic [1:0]    done;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // reference model state: who was served last (1 after reset)
   logic last_m = 1'b1;

   pit_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .base_addr0 (base_addr0),
      .base_addr1 (base_addr1),
      .wdata0     (wdata0),
      .mem_rdata  (mem_rdata),
      .gnt        (gnt),
      .wr_pop0    (wr_pop0),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .rdata1     (rdata1),
      .rvalid1    (rvalid1),
      .done       (done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // memory model: each byte reads back as the low byte of its address
   assign mem_rdata = mem_addr[7:0];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[AW-1:0];
   endfunction

   // One complete burst: request, check grant, every access, done and gap.
   task automatic do_burst(input logic [1:0] r, input logic [AW-1:0] b0,
                           input logic [AW-1:0] b1, input bit drop, input string tag);
      logic          exp_o;
      logic [AW-1:0] b;
      logic [AW-1:0] ea;
      logic [DW-1:0] wd [BL];
      logic [1:0]    exp_g;
      exp_o = (r == 2'b11) ? ~last_m : r[1];
      b     = exp_o ? b1 : b0;
      exp_g = exp_o ? 2'b10 : 2'b01;
      for (int i = 0; i < BL; i++) wd[i] = 8'($urandom);
      req = r; base_addr0 = b0; base_addr1 = b1; wdata0 = 8'($urandom);
      tick();
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL %s gnt got %b want %b", tag, gnt, exp_g); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_grant got %b want 1", tag, busy); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL %s we_grant got %b want 0", tag, mem_we); end
      // base addresses must already be captured; scramble them now
      base_addr0 = rand_addr(); base_addr1 = rand_addr();
      tick();
      for (int i = 0; i < BL; i++) begin
         wdata0 = wd[i];
         checks++; if (wr_pop0 !== ~exp_o) begin errors++; $display("FAIL %s wr_pop0[%0d] got %b want %b", tag, i, wr_pop0, ~exp_o); end
         tick();
         if (drop && i == 0) req = 2'b00;
         ea = b + AW'(i);
         checks++; if (mem_addr !== ea) begin errors++; $display("FAIL %s addr[%0d] got %h want %h", tag, i, mem_addr, ea); end
         checks++; if (mem_we !== ~exp_o) begin errors++; $display("FAIL %s we[%0d] got %b want %b", tag, i, mem_we, ~exp_o); end
         checks++; if (rvalid1 !== exp_o) begin errors++; $display("FAIL %s rvalid1[%0d] got %b want %b", tag, i, rvalid1, exp_o); end
         if (!exp_o) begin
            checks++; if (mem_wdata !== wd[i]) begin errors++; $display("FAIL %s wdata[%0d] got %h want %h", tag, i, mem_wdata, wd[i]); end
         end else begin
            checks++; if (rdata1 !== ea[7:0]) begin errors++; $display("FAIL %s rdata1[%0d] got %h want %h", tag, i, rdata1, ea[7:0]); end
         end
         checks++; if (gnt !== exp_g) begin errors++; $display("FAIL %s gnt_hold[%0d] got %b want %b", tag, i, gnt, exp_g); end
         checks++; if (done !== 2'b00) begin errors++; $display("FAIL %s done_early[%0d] got %b want 00", tag, i, done); end
      end
      // now in the DONE cycle: no further pop request
      checks++; if (wr_pop0 !== 1'b0) begin errors++; $display("FAIL %s wr_pop0_done got %b want 0", tag, wr_pop0); end
      tick();
      checks++; if (done !== exp_g) begin errors++; $display("FAIL %s done got %b want %b", tag, done, exp_g); end
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL %s gnt_gap got %b want 00", tag, gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_gap got %b want 0", tag, busy); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL %s we_gap got %b want 0", tag, mem_we); end
      checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL %s rvalid1_gap got %b want 0", tag, rvalid1); end
      last_m = exp_o;
      req = 2'b00;
   endtask

   task automatic check_all_zero(input string tag);
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL %s gnt got %b want 00", tag, gnt); end
      checks++; if (done !== 2'b00) begin errors++; $display("FAIL %s done got %b want 00", tag, done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", tag, busy); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL %s mem_we got %b want 0", tag, mem_we); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL %s mem_addr got %h want 0", tag, mem_addr); end
      checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL %s mem_wdata got %h want 0", tag, mem_wdata); end
      checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL %s rvalid1 got %b want 0", tag, rvalid1); end
      checks++; if (rdata1 !== '0) begin errors++; $display("FAIL %s rdata1 got %h want 0", tag, rdata1); end
      checks++; if (wr_pop0 !== 1'b0) begin errors++; $display("FAIL %s wr_pop0 got %b want 0", tag, wr_pop0); end
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 2'b00; base_addr0 = '0; base_addr1 = '0; wdata0 = '0;
      tick(); tick();
      check_all_zero("reset");
      reset = 1'b0;
      last_m = 1'b1;
   endtask

   task automatic test_idle();
      req = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL idle gnt/busy got %b/%b want 00/0", gnt, busy); end
      end
   endtask

   task automatic test_single_write();
      do_burst(2'b01, AW'(64'h10), rand_addr(), 1'b0, "write");
   endtask

   task automatic test_single_read();
      do_burst(2'b10, rand_addr(), AW'(64'h20), 1'b0, "read");
   endtask

   task automatic test_round_robin();
      // the model must expect 0,1,0,1 starting from last_m = 1
      last_m = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++; if ((~last_m) !== k[0]) begin errors++; $display("FAIL rr_order burst %0d got %b want %b", k, ~last_m, k[0]); end
         do_burst(2'b11, rand_addr(), rand_addr(), 1'b0, "rr");
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] top;
      top = '1;
      top = top - AW'(1);
      do_burst(2'b01, top, rand_addr(), 1'b0, "wrap");
   endtask

   task automatic test_drop();
      do_burst(2'b01, rand_addr(), rand_addr(), 1'b1, "drop");
   endtask

   task automatic test_random();
      logic [1:0] r;
      for (int k = 0; k < 20; k++) begin
         r = 2'($urandom_range(1, 3));
         do_burst(r, rand_addr(), rand_addr(), 1'($urandom), "rand");
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   task automatic test_reset_mid();
      req = 2'b01; base_addr0 = rand_addr(); wdata0 = 8'($urandom);
      tick();            // grant
      tick();            // first BURST cycle
      wdata0 = 8'($urandom);
      tick();            // second BURST cycle
      reset = 1'b1;
      tick();
      check_all_zero("reset_mid");
      reset = 1'b0;
      req = 2'b00;
      last_m = 1'b1;
      checks++; if (last_m !== 1'b1) begin errors++; $display("FAIL reset_mid model got %b want 1", last_m); end
      do_burst(2'b11, rand_addr(), rand_addr(), 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_write();
      test_single_read();
      test_round_robin();
      test_wrap();
      test_drop();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
